// File: rtl/ram256x16_arbiter_if.sv
// Requester-side bus of the RAM256x16 arbiter: two read ports (A, B), one write port and BUSY.
// Handshake: X_REQ/W_REQ act as valid and X_GNT/W_ACK as ready; a transfer happens in a cycle where both are high, and an ungranted requester holds REQ and address stable until granted.
interface ram256x16_arbiter_if;
    logic        A_REQ;
    logic [7:0]  A_ADDR;
    logic        A_GNT;
    logic        A_VALID;
    logic        B_REQ;
    logic [7:0]  B_ADDR;
    logic        B_GNT;
    logic        B_VALID;
    logic [15:0] RDATA;
    logic        W_REQ;
    logic [7:0]  W_ADDR;
    logic [15:0] W_DATA;
    logic [15:0] W_MASK;
    logic        W_ACK;
    logic        BUSY;

    modport master (
        output A_REQ, A_ADDR, B_REQ, B_ADDR, W_REQ, W_ADDR, W_DATA, W_MASK,
        input  A_GNT, A_VALID, B_GNT, B_VALID, RDATA, W_ACK, BUSY
    );

    modport slave (
        input  A_REQ, A_ADDR, B_REQ, B_ADDR, W_REQ, W_ADDR, W_DATA, W_MASK,
        output A_GNT, A_VALID, B_GNT, B_VALID, RDATA, W_ACK, BUSY
    );
endinterface

// File: rtl/ram256x16_arbiter.sv
// Controller for one iCE40 RAM256x16: round-robin read sharing between A and B, a pass-through
// write port with read/write collision blocking, and an optional post-reset clear of all 256 words.
module ram256x16_arbiter #(
    parameter bit          CLR_EN    = 1'b1,
    parameter logic [15:0] CLR_VALUE = 16'h0000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    ram256x16_arbiter_if.slave        bus,
    output logic                      RAM_RE,
    output logic                      RAM_RCLKE,
    output logic                      RAM_WE,
    output logic                      RAM_WCLKE,
    output logic [7:0]                RAM_RADDR,
    output logic [7:0]                RAM_WADDR,
    output logic [15:0]               RAM_WDATA,
    output logic [15:0]               RAM_MASK,
    input  logic [15:0]               RAM_RDATA,
    output logic                      o_dbg_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic [7:0]  r_cnt;
    logic        r_last_b;
    logic        r_a_valid;
    logic        r_b_valid;

    logic        w_run;
    logic        w_a_hit;
    logic        w_b_hit;
    logic        w_a_elig;
    logic        w_b_elig;
    logic        w_a_gnt;
    logic        w_b_gnt;
    logic        w_w_ack;

    // A read is held off while the same address is being written, so it never samples a half-updated word.
    assign w_run    = !r_busy;
    assign w_a_hit  = bus.W_REQ && (bus.W_ADDR == bus.A_ADDR);
    assign w_b_hit  = bus.W_REQ && (bus.W_ADDR == bus.B_ADDR);
    assign w_a_elig = w_run && bus.A_REQ && !w_a_hit;
    assign w_b_elig = w_run && bus.B_REQ && !w_b_hit;
    assign w_a_gnt  = w_a_elig && (!w_b_elig || r_last_b);
    assign w_b_gnt  = w_b_elig && (!w_a_elig || !r_last_b);
    assign w_w_ack  = w_run && bus.W_REQ;

    assign bus.A_GNT   = w_a_gnt;
    assign bus.B_GNT   = w_b_gnt;
    assign bus.A_VALID = r_a_valid;
    assign bus.B_VALID = r_b_valid;
    assign bus.RDATA   = RAM_RDATA;
    assign bus.W_ACK   = w_w_ack;
    assign bus.BUSY    = r_busy;

    assign RAM_RCLKE = 1'b1;
    assign RAM_WCLKE = 1'b1;
    assign RAM_RE    = w_a_gnt || w_b_gnt;
    assign RAM_RADDR = w_b_gnt ? bus.B_ADDR : bus.A_ADDR;

    // The clear sequencer owns the write port while busy.
    assign RAM_WE    = r_busy || w_w_ack;
    assign RAM_WADDR = r_busy ? r_cnt : bus.W_ADDR;
    assign RAM_WDATA = r_busy ? CLR_VALUE : bus.W_DATA;
    assign RAM_MASK  = r_busy ? 16'h0000 : bus.W_MASK;

    assign o_dbg_state = logic'(r_state);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= CLR_EN ? ST_INIT : ST_RUN;
            r_busy    <= CLR_EN;
            r_cnt     <= 8'h00;
            r_last_b  <= 1'b1;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
        end else begin
            r_a_valid <= w_a_gnt;
            r_b_valid <= w_b_gnt;
            if (w_a_gnt) begin
                r_last_b <= 1'b0;
            end else if (w_b_gnt) begin
                r_last_b <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == 8'hFF) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
